// File: rtl/accum_mw_seq.sv
// ----------------------------------------------------------------------------
// accum_mw_seq
//
// Multi-word accumulate sequencer. Performs ACC = ACC +/- OPERAND on an
// NWORDS x 16-bit accumulator by time-sharing one external 16-bit adder
// slice, one word per cycle, least-significant word first. The adder's cascade
// output (carry on add, borrow on subtract) is registered and fed back as the
// carry-in of the next word.
//
// Sequence: IDLE (accept) -> RUN (NWORDS cycles) -> DONE (1 cycle) -> IDLE.
//
// Build option:
//   ACCUM_MW_SATURATE_EN - when defined, a signed overflow on the final word
//                          clamps the whole accumulator to the most positive or
//                          most negative value instead of wrapping. OVERFLOW is
//                          reported in both builds and latency is unchanged.
// ----------------------------------------------------------------------------
module accum_mw_seq #(
    parameter int unsigned NWORDS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    // Requester side
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [16*NWORDS-1:0]   operand_i,
    input  logic                   addsub_i,
    input  logic                   clear_i,
    output logic [16*NWORDS-1:0]   acc_out_o,
    output logic                   out_valid_o,
    output logic                   overflow_o,

    // External 16-bit adder slice
    output logic [15:0]            add_a_o,
    output logic [15:0]            add_b_o,
    output logic                   add_addsub_o,
    output logic                   add_ci_o,
    input  logic [15:0]            add_sum_i,
    input  logic                   add_cocas_i
);

    localparam int unsigned W    = 16 * NWORDS;
    localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Clamp values used when saturation is enabled.
    localparam logic [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q,   idx_d;
    logic [W-1:0]    acc_q,   acc_d;
    logic [W-1:0]    opnd_q,  opnd_d;
    logic            op_q,    op_d;
    logic            cas_q,   cas_d;
    logic            ovf_q,   ovf_d;

    logic [15:0]     acc_word;
    logic [15:0]     opnd_word;
    logic            is_run;
    logic            is_last;
    logic            sa, sb, sr;
    logic            ovf_calc;

    assign is_run  = (state_q == StRun);
    assign is_last = (idx_q == LastIdx);

    // Select the accumulator and operand words addressed by the word index.
    always_comb begin
        acc_word  = '0;
        opnd_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (idx_q == IdxW'(i)) begin
                acc_word  = acc_q[16*i +: 16];
                opnd_word = opnd_q[16*i +: 16];
            end
        end
    end

    // Signed overflow of the full-width result, evaluated on the final word.
    // sa is taken from the accumulator before the MSW is overwritten.
    always_comb begin
        sa = acc_q[W-1];
        sb = opnd_q[W-1];
        sr = add_sum_i[15];
        if (op_q) begin
            ovf_calc = (sa != sb) && (sr != sa);
        end else begin
            ovf_calc = (sa == sb) && (sr != sa);
        end
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        cas_d   = cas_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    opnd_d  = operand_i;
                    op_d    = addsub_i;
                    idx_d   = '0;
                    cas_d   = 1'b0;
                    if (clear_i) begin
                        acc_d = '0;
                    end
                    state_d = StRun;
                end
            end

            StRun: begin
                for (int unsigned i = 0; i < NWORDS; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        acc_d[16*i +: 16] = add_sum_i;
                    end
                end
                cas_d = add_cocas_i;
                if (is_last) begin
                    ovf_d   = ovf_calc;
                    idx_d   = '0;
                    state_d = StDone;
`ifdef ACCUM_MW_SATURATE_EN
                    // Clamp toward the sign of the original accumulator.
                    if (ovf_calc) begin
                        acc_d = sa ? SatMin : SatMax;
                    end
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= 1'b0;
            cas_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            cas_q   <= cas_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake/status outputs and adder drive; adder inputs are quiet outside RUN.
    always_comb begin
        in_ready_o   = (state_q == StIdle);
        out_valid_o  = (state_q == StDone);
        acc_out_o    = acc_q;
        overflow_o   = ovf_q;
        add_a_o      = is_run ? acc_word  : 16'h0000;
        add_b_o      = is_run ? opnd_word : 16'h0000;
        add_addsub_o = is_run ? op_q      : 1'b0;
        // cas_q is cleared on accept, so word 0 always sees CI = 0.
        add_ci_o     = is_run ? cas_q     : 1'b0;
    end

endmodule

// File: tb/tb_accum_mw_seq.sv
// ----------------------------------------------------------------------------
// tb_accum_mw_seq
//
// Directed bench for accum_mw_seq with NWORDS = 3, including a behavioural
// model of the external 16-bit adder slice. Define ACCUM_MW_SATURATE_EN for
// both files to exercise the saturating build.
// ----------------------------------------------------------------------------
module tb_accum_mw_seq;

    localparam int unsigned NW = 3;
    localparam int unsigned W  = 16 * NW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  operand;
    logic          addsub;
    logic          clear;
    logic [W-1:0]  acc_out;
    logic          out_valid;
    logic          overflow;
    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_addsub;
    logic          add_ci;
    logic [15:0]   add_sum;
    logic          add_cocas;

    int            checks;
    int            errors;
    logic [NW-1:0] ci_seen;

`ifdef ACCUM_MW_SATURATE_EN
    localparam logic [W-1:0] ExpOvfAdd = 48'h7FFF_FFFF_FFFF;
    localparam logic [W-1:0] ExpOvfSub = 48'h8000_0000_0000;
`else
    localparam logic [W-1:0] ExpOvfAdd = 48'h8000_0000_0000;
    localparam logic [W-1:0] ExpOvfSub = 48'h7FFF_FFFF_FFFF;
`endif

    accum_mw_seq #(
        .NWORDS (NW)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .operand_i    (operand),
        .addsub_i     (addsub),
        .clear_i      (clear),
        .acc_out_o    (acc_out),
        .out_valid_o  (out_valid),
        .overflow_o   (overflow),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_addsub_o (add_addsub),
        .add_ci_o     (add_ci),
        .add_sum_i    (add_sum),
        .add_cocas_i  (add_cocas)
    );

    // Adder slice model: A + B + CI, or A - B - CI with COCAS as borrow.
    always_comb begin
        logic [16:0] t;
        if (add_addsub) begin
            t = {1'b0, add_a} - {1'b0, add_b} - {16'h0000, add_ci};
        end else begin
            t = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_ci};
        end
        add_sum   = t[15:0];
        add_cocas = t[16];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and check latency, result and pulse width.
    task automatic do_op(input logic [W-1:0] opnd, input logic sub, input logic clr,
                         input logic [W-1:0] exp_acc, input logic exp_ovf, input string tag);
        int  k;
        bit  done;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        operand  = opnd;
        addsub   = sub;
        clear    = clr;
        k        = 0;
        done     = 0;
        ci_seen  = '0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                // Post-accept changes must not disturb the operation.
                in_valid = 1'b0;
                operand  = ~opnd;
                addsub   = ~sub;
                clear    = 1'b1;
            end
            if (k <= NW) ci_seen[k-1] = add_ci;
            if (out_valid) done = 1;
        end
        clear = 1'b0;
        // RUN occupies cycles 1..NW after the accept edge, DONE is cycle NW+1.
        check({tag, "_lat"}, 64'(k), 64'(NW + 1));
        check({tag, "_acc"}, 64'(acc_out), 64'(exp_acc));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_adda_done"}, 64'(add_a), 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int pulses;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        operand  = '0;
        addsub   = 1'b0;
        clear    = 1'b0;
        ci_seen  = '0;

        repeat (2) @(negedge clk);
        check("rst_acc",   64'(acc_out),   64'd0);
        check("rst_rdy",   64'(in_ready),  64'd1);
        check("rst_vld",   64'(out_valid), 64'd0);
        check("rst_ovf",   64'(overflow),  64'd0);
        check("rst_adda",  64'(add_a),     64'd0);
        check("rst_ci",    64'(add_ci),    64'd0);
        rst_n = 1'b1;

        // Carry out of word 0 into word 1.
        do_op(48'h0000_0000_FFFF, 1'b0, 1'b1, 48'h0000_0000_FFFF, 1'b0, "add_ffff");
        do_op(48'h0000_0000_0001, 1'b0, 1'b0, 48'h0000_0001_0000, 1'b0, "add_one");

        // Borrow ripples through every word.
        do_op(48'h0000_0000_0001, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, "sub_one");
        check("sub_one_ci", 64'(ci_seen), 64'b110);

        // Positive overflow.
        do_op(48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b0, "ld_max");
        do_op(48'h0000_0000_0001, 1'b0, 1'b0, ExpOvfAdd, 1'b1, "ovf_add");
        repeat (3) @(negedge clk);
        check("ovf_hold", 64'(overflow), 64'd1);

        // Negative overflow; the load also shows OVERFLOW clearing.
        do_op(48'h8000_0000_0000, 1'b0, 1'b1, 48'h8000_0000_0000, 1'b0, "ld_min");
        do_op(48'h0000_0000_0001, 1'b1, 1'b0, ExpOvfSub, 1'b1, "ovf_sub");

        // CLEAR without IN_VALID does nothing.
        @(negedge clk);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check("clr_novld_acc", 64'(acc_out), 64'(ExpOvfSub));
        check("clr_novld_rdy", 64'(in_ready), 64'd1);

        // Back-to-back with IN_VALID held: second request clears and adds 5.
        @(negedge clk);
        in_valid = 1'b1;
        operand  = 48'h1234_5678_9ABC;
        addsub   = 1'b0;
        clear    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) operand = 48'h0000_0000_0005;
            if (k <= 4) check("b2b_busy1", 64'(in_ready), 64'd0);
            if (k == 4) begin
                check("b2b_vld1", 64'(out_valid), 64'd1);
                check("b2b_acc1", 64'(acc_out), 64'h1234_5678_9ABC);
            end
            if (k == 5) check("b2b_idle", 64'(in_ready), 64'd1);
            if (k >= 6 && k <= 8) check("b2b_busy2", 64'(in_ready), 64'd0);
            if (k == 9) begin
                check("b2b_vld2", 64'(out_valid), 64'd1);
                check("b2b_acc2", 64'(acc_out), 64'h0000_0000_0005);
            end
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);

        // Reset asserted during RUN word 1 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        operand  = 48'h1111_1111_1111;
        addsub   = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        check("mid_in_run", 64'(add_b), 64'h1111);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", 64'(acc_out), 64'd0);
        check("mid_rst_rdy", 64'(in_ready), 64'd1);
        check("mid_rst_vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid_rst_nopulse", 64'(pulses), 64'd0);
        do_op(48'h0000_0000_0007, 1'b0, 1'b0, 48'h0000_0000_0007, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
